// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// performs the access and pulses a response; stalls upstream meanwhile.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we, r_signed;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept, w_access, w_sel;
  logic          w_we, w_signed, w_fault;
  logic [31:0]   w_addr, w_wdata, w_word, w_rd, w_wd, w_b, w_h;
  logic [1:0]    w_size;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid)
                w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    stall      = ((r_state == S_IDLE) && req_valid) || (r_state == S_WAIT);
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_access = (w_accept && (WAIT_CYCLES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // Zero wait states access straight from the request inputs.
  assign w_sel    = (r_state == S_IDLE);
  assign w_we     = w_sel ? req_we     : r_we;
  assign w_addr   = w_sel ? req_addr   : r_addr;
  assign w_wdata  = w_sel ? req_wdata  : r_wdata;
  assign w_size   = w_sel ? req_size   : r_size;
  assign w_signed = w_sel ? req_signed : r_signed;

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_b    = w_word >> {w_addr[1:0], 3'b000};
  assign w_h    = w_word >> {w_addr[1], 4'b0000};

  always_comb begin
    w_fault = |(w_addr >> (AW + 2));
    w_be    = 4'b0000;
    w_wd    = w_wdata;
    w_rd    = 32'h0;
    case (w_size)
      2'b00: begin
        w_be = 4'b0001 << w_addr[1:0];
        w_wd = {4{w_wdata[7:0]}};
        w_rd = {{24{w_signed & w_b[7]}}, w_b[7:0]};
      end
      2'b01: begin
        w_fault = w_fault | w_addr[0];
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd    = {2{w_wdata[15:0]}};
        w_rd    = {{16{w_signed & w_h[15]}}, w_h[15:0]};
      end
      2'b10: begin
        w_fault = w_fault | (w_addr[1:0] != 2'b00);
        w_be    = 4'b1111;
        w_rd    = w_word;
      end
      default: w_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= 4'(WAIT_CYCLES);
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_size   <= req_size;
        r_signed <= req_signed;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= (w_fault || w_we) ? 32'h0 : w_rd;
        r_err   <= w_fault;
      end
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_access && w_we && !w_fault) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int WC    = 2;
  localparam int LIM   = 4 * DEPTH;

  logic        clk = 0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] mm [LIM];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz,
                                input logic sg, input bit upd,
                                output logic [31:0] rd, output logic err);
    int unsigned nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rd = 0;
    err = (sz == 2'd3) || (a % nb != 0) || (a >= LIM);
    if (err) return;
    if (we) begin
      if (upd)
        for (int i = 0; i < nb; i++) mm[a+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v |= 32'(mm[a+i]) << (8*i);
      if (sg && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8*nb);
      rd = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic sg);
    logic [31:0] erd;
    logic eerr;
    int n;
    bit seen;
    model(we, a, wd, sz, sg, 1'b1, erd, eerr);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = wd; req_size = sz; req_signed = sg;
    #1;
    chk("rdy_acc", req_ready, 1);
    chk("stall_acc", stall, 1);
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_size = 2'($urandom); req_signed = 1'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid) seen = 1;
      else begin
        chk("stall_wait", stall, 1);
        chk("rdy_wait", req_ready, 0);
      end
    end
    chk("latency", n, WC + 1);
    chk("rdata", resp_rdata, erd);
    chk("err", resp_err, eerr);
    chk("stall_resp", stall, 0);
    chk("rdy_resp", req_ready, 0);
    @(negedge clk);
    chk("pulse", resp_valid, 0);
    chk("hold_rdata", resp_rdata, erd);
    chk("hold_err", resp_err, eerr);
  endtask

  initial begin
    logic [31:0] erd, a;
    logic eerr;
    int acc, rsp, cyc, pulses;
    rstn = 0; req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_size = 0; req_signed = 0;
    #12;
    chk("rst_rdy", req_ready, 1);
    chk("rst_vld", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_stall0", stall, 0);
    req_valid = 1; #1;
    chk("rst_stall1", stall, 1);
    req_valid = 0;
    @(negedge clk); rstn = 1;

    for (int w = 0; w < DEPTH; w++)
      do_req(1, 32'(4*w), $urandom, 2'd2, 0);

    do_req(1, 32'h10, 32'hDEADBEEF, 2'd2, 0);
    do_req(0, 32'h10, 0, 2'd2, 1);
    chk("spec_w", resp_rdata, 32'hDEADBEEF);
    do_req(0, 32'h13, 0, 2'd0, 1);
    chk("spec_bs", resp_rdata, 32'hFFFFFFDE);
    do_req(0, 32'h13, 0, 2'd0, 0);
    chk("spec_bu", resp_rdata, 32'h000000DE);
    do_req(0, 32'h10, 0, 2'd1, 1);
    chk("spec_hs", resp_rdata, 32'hFFFFBEEF);
    do_req(1, 32'h11, 32'h55, 2'd0, 0);
    do_req(0, 32'h10, 0, 2'd2, 0);
    chk("spec_merge", resp_rdata, 32'hDEAD55EF);
    do_req(0, 32'h12, 0, 2'd2, 0);
    chk("flt_w", resp_err, 1);
    do_req(1, 32'h01, 32'hFFFF, 2'd1, 0);
    chk("flt_h", resp_err, 1);
    do_req(1, 32'h10, 32'h0, 2'd3, 0);
    chk("flt_sz", resp_err, 1);
    do_req(0, 32'(LIM), 0, 2'd2, 0);
    chk("flt_oor", resp_err, 1);
    do_req(0, 32'h10, 0, 2'd2, 0);
    chk("flt_nochg", resp_rdata, 32'hDEAD55EF);

    // reset in the middle of a store's wait phase
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_size = 2'd2; req_signed = 0;
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk); rstn = 0; #1;
    chk("mr_rdy", req_ready, 1);
    chk("mr_vld", resp_valid, 0);
    chk("mr_stall", stall, 0);
    chk("mr_rdata", resp_rdata, 0);
    chk("mr_err", resp_err, 0);
    @(negedge clk); rstn = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("mr_noresp", pulses, 0);
    do_req(0, 32'h20, 0, 2'd2, 0);

    // three back-to-back requests with req_valid held high
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    req_size = 2'd2; req_signed = 0;
    model(0, 32'h10, 0, 2'd2, 0, 1'b0, erd, eerr);
    acc = 0; rsp = 0; cyc = 0;
    #1;
    while ((acc < 3 || rsp < 3) && cyc < 60) begin
      chk("b2b_rdy", req_ready,
          (cyc % (WC+2) == 0 && cyc < 3*(WC+2)) ? 1 : 0);
      chk("b2b_vld", resp_valid, (cyc % (WC+2) == WC+1) ? 1 : 0);
      chk("b2b_stall", stall, resp_valid ? 0 : 1);
      if (resp_valid) begin
        rsp++;
        chk("b2b_rdata", resp_rdata, erd);
      end
      if (req_ready) begin
        acc++;
        if (acc == 3) begin
          @(posedge clk); #1; req_valid = 0;
        end
      end
      @(negedge clk); #1;
      cyc++;
    end
    chk("b2b_acc", acc, 3);
    chk("b2b_resp", rsp, 3);

    for (int k = 0; k < 250; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom
                                      : 32'($urandom_range(0, LIM + 15));
      if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
      do_req(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words of data storage (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0..15).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  memory stage presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_signed  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-012 resp_valid  output  1  one-cycle pulse marking completion of the accepted request.
REQ-013 resp_rdata  output  32  load data, valid while resp_valid is high.
REQ-014 resp_err  output  1  request faulted (misaligned, illegal size, out of range); valid with resp_valid.
REQ-015 stall  output  1  freezes upstream pipeline stages while a request is outstanding.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid, latch we/addr/wdata/size/signed, load wait counter with WAIT_CYCLES, go to WAIT (or directly to RESP when WAIT_CYCLES = 0).
REQ-018 WAIT: decrement counter each cycle; on the cycle the counter reads 1, perform the access and go to RESP.
REQ-019 RESP: resp_valid = 1 for exactly one cycle, then return to IDLE; no new request is accepted in RESP.
REQ-020 Latency from acceptance edge to resp_valid high = WAIT_CYCLES + 1 cycles; back-to-back throughput one request per WAIT_CYCLES + 2 cycles.
REQ-021 stall = (IDLE and req_valid) or WAIT; stall = 0 in RESP so upstream advances on the response cycle.
REQ-022 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
REQ-023 Fault if: size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00; addr >= 4*DEPTH_WORDS.
REQ-024 A faulted request writes nothing, returns resp_rdata = 0 and resp_err = 1.
REQ-025 Store: byte writes lane addr[1:0] with wdata[7:0]; halfword writes lanes addr[1]*2 and +1 with wdata[15:0]; word writes all lanes; unwritten lanes preserved.
REQ-026 Load: selected byte/halfword moved to bit 0, then sign- or zero-extended per req_signed; word returned unmodified; store response returns resp_rdata = 0.
REQ-027 A load following a store to the same address returns the stored value (write completes before the later request's access).
REQ-028 Request inputs are ignored outside the IDLE acceptance cycle; changes during WAIT do not affect the latched request.
REQ-029 resp_rdata and resp_err hold their value from the RESP cycle until the next RESP.

Reset
REQ-030 rstn low forces, asynchronously: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready then reads 1 and stall follows req_valid.
REQ-031 Reset during WAIT abandons the request: no response issued and any pending store is not performed.
REQ-032 Storage contents are not cleared by reset.

Verification
REQ-033 WAIT_CYCLES=2; store word 0xDEADBEEF @0x10, then load word signed @0x10 -> each resp_valid 3 cycles after acceptance; load returns 0xDEADBEEF, resp_err 0.
REQ-034 After REQ-033: load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x10 signed -> 0xFFFFBEEF.
REQ-035 Store byte 0x55 @0x11 over 0xDEADBEEF -> load word @0x10 returns 0xDEAD55EF.
REQ-036 Load word @0x12, half @0x01, size 11, load @4*DEPTH_WORDS -> resp_err 1, resp_rdata 0, memory unchanged.
REQ-037 Assert rstn low in WAIT of a store 0x12345678 @0x20 -> no resp_valid; after release, load @0x20 returns the pre-store value.
REQ-038 Hold req_valid high with 3 queued requests -> stall high except each RESP cycle, req_ready high only in IDLE, exactly 3 resp_valid pulses.
